// File: rtl/pin_bank_ctrl_pkg.sv
// Shared definitions for the pad/reset glue: sequencer state encodings and
// the default parameter set used by pin_bank_ctrl and pin_sync.
package pin_bank_ctrl_pkg;

   typedef enum logic [1:0] {
      SEQ_HOLD    = 2'd0,
      SEQ_STRETCH = 2'd1,
      SEQ_RUN     = 2'd2,
      SEQ_SWRES   = 2'd3
   } seq_state_e;

   localparam int DEF_PORTS         = 2;
   localparam int DEF_WIDTH         = 32;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_RST_CYCLES    = 16;
   localparam int DEF_SW_RST_CYCLES = 4;
   localparam int DEF_CNT_W         = 24;

endpackage

// File: rtl/pin_sync.sv
// One bank of pad input synchronisers plus a registered "any pin changed"
// strobe comparing the synchronised value against the previous cycle.
module pin_sync
   import pin_bank_ctrl_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             res,
   input  logic             chg_en,
   input  logic [WIDTH-1:0] pad_in,
   output logic [WIDTH-1:0] pin_in,
   output logic             pin_chg
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q, stage_d;
   logic [WIDTH-1:0]                  prev_q, prev_d;
   logic                              chg_q, chg_d;

   always_comb begin
      stage_d = {stage_q[SYNC_STAGES-2:0], pad_in};
      prev_d  = stage_q[SYNC_STAGES-1];
      // chg_en follows the sequencer's next state so the strobe is never
      // visible while run is low.
      chg_d   = chg_en && (stage_q[SYNC_STAGES-1] != prev_q);
   end

   always_ff @(posedge clk) begin
      if (res) begin
         stage_q <= '0;
         prev_q  <= '0;
         chg_q   <= 1'b0;
      end else begin
         stage_q <= stage_d;
         prev_q  <= prev_d;
         chg_q   <= chg_d;
      end
   end

   assign pin_in  = stage_q[SYNC_STAGES-1];
   assign pin_chg = chg_q;

endmodule

// File: rtl/pin_bank_ctrl.sv
// Pad/reset glue between the FPGA pads and the core: reset stretcher and
// software-reset sequencer, gated pad output registers, input synchronisers.
module pin_bank_ctrl
   import pin_bank_ctrl_pkg::*;
#(
   parameter int PORTS         = DEF_PORTS,
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int SW_RST_CYCLES = DEF_SW_RST_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic                   clk,
   input  logic                   res,
   input  logic                   sw_res,
   input  logic [PORTS*WIDTH-1:0] pin_out,
   input  logic [PORTS*WIDTH-1:0] pin_dir,
   input  logic [PORTS*WIDTH-1:0] pad_in,
   output logic [PORTS*WIDTH-1:0] pad_o,
   output logic [PORTS*WIDTH-1:0] pad_oe,
   output logic [PORTS*WIDTH-1:0] pin_in,
   output logic [PORTS-1:0]       pin_chg,
   output logic                   nres,
   output logic                   run
);

   localparam int N = PORTS * WIDTH;
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SW_RST_CYCLES - 1);
   localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 64'sd1;

   generate
      if (PORTS < 1 || PORTS > 4) begin : g_bad_ports
         $error("pin_bank_ctrl: PORTS must be 1..4");
      end
      if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
         $error("pin_bank_ctrl: SYNC_STAGES must be 2..4");
      end
      if (CNT_W < 1 || CNT_W > 62 || RST_CYCLES < 1 || longint'(RST_CYCLES) > CNT_MAX) begin : g_bad_rst
         $error("pin_bank_ctrl: RST_CYCLES must be 1..2**CNT_W-1");
      end
      if (SW_RST_CYCLES < 1 || (CNT_W <= 62 && longint'(SW_RST_CYCLES) > CNT_MAX)) begin : g_bad_swrst
         $error("pin_bank_ctrl: SW_RST_CYCLES must be >=1 and fit in CNT_W bits");
      end
   endgenerate

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             nres_q, nres_d;
   logic             run_q, run_d;
   logic [N-1:0]     pad_o_q, pad_o_d;
   logic [N-1:0]     pad_oe_q, pad_oe_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         SEQ_HOLD: begin
            state_d = SEQ_STRETCH;
            cnt_d   = '0;
         end
         SEQ_STRETCH: begin
            if (cnt_q == RST_LAST) begin
               state_d = SEQ_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SEQ_RUN: begin
            if (sw_res) begin
               state_d = SEQ_SWRES;
               cnt_d   = '0;
            end
         end
         SEQ_SWRES: begin
            // Saturate at the minimum hold, then wait for the request to drop.
            if (cnt_q < SW_LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else if (!sw_res) begin
               state_d = SEQ_RUN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = SEQ_HOLD;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered from the next state so nres, run and the pad
      // gating all change on the same edge as the state itself.
      run_d    = (state_d == SEQ_RUN);
      nres_d   = run_d;
      pad_o_d  = pin_out & {N{run_d}};
      pad_oe_d = pin_dir & {N{run_d}};
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q  <= SEQ_HOLD;
         cnt_q    <= '0;
         nres_q   <= 1'b0;
         run_q    <= 1'b0;
         pad_o_q  <= '0;
         pad_oe_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         nres_q   <= nres_d;
         run_q    <= run_d;
         pad_o_q  <= pad_o_d;
         pad_oe_q <= pad_oe_d;
      end
   end

   for (genvar gi = 0; gi < PORTS; gi++) begin : g_bank
      pin_sync #(
         .WIDTH       (WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk     (clk),
         .res     (res),
         .chg_en  (run_d),
         .pad_in  (pad_in[gi*WIDTH +: WIDTH]),
         .pin_in  (pin_in[gi*WIDTH +: WIDTH]),
         .pin_chg (pin_chg[gi])
      );
   end

   assign pad_o  = pad_o_q;
   assign pad_oe = pad_oe_q;
   assign nres   = nres_q;
   assign run    = run_q;

endmodule

// File: doc/pin_bank_ctrl.md
Name: pin_bank_ctrl

Overview:
Parametrised successor to the single-port pad/reset glue at the top level. It generalises that glue to PORTS banks of WIDTH pins each and adds:
- registered, tristate-gated pad drivers;
- multi-stage input synchronisers with per-pin change strobes;
- a reset sequencer that stretches external and software resets and produces the core's active-low nres.

It sits between the FPGA pads and the dig core, clocked by clk_cog.

Parameters:
PORTS, 2, number of pin banks (1..4).
WIDTH, 32, pins per bank.
SYNC_STAGES, 2, input synchroniser depth (2..4).
RST_CYCLES, 16, cycles nres stays low after res deasserts (1..2^CNT_W-1).
SW_RST_CYCLES, 4, minimum cycles nres stays low for a software reset (>=1).
CNT_W, 24, sequencer counter width.

Ports:
clk  input  1  core clock (clk_cog); every flop uses its rising edge.
res  input  1  synchronous, active-high reset.
sw_res  input  1  software reset request (cfg[7]), level-sensitive.
pin_out  input  PORTS*WIDTH  core output values; bank p occupies bits [p*WIDTH +: WIDTH].
pin_dir  input  PORTS*WIDTH  core direction bits; 1 = drive.
pad_in  input  PORTS*WIDTH  raw pad levels, asynchronous.
pad_o  output  PORTS*WIDTH  registered pad output value.
pad_oe  output  PORTS*WIDTH  registered pad output enable; the top level applies the tristate.
pin_in  output  PORTS*WIDTH  synchronised pad levels to the core.
pin_chg  output  PORTS  per-bank one-cycle strobe: any pin in the bank changed.
nres  output  1  active-low core reset.
run  output  1  sequencer is in state RUN.

Behaviour:
- Reset values, applied whenever res=1, override everything else:
  - nres=0, run=0;
  - pad_o=0, pad_oe=0, pin_in=0, pin_chg=0;
  - all synchroniser flops=0, counter=0.
- Sequencer states: HOLD, STRETCH, RUN, SWRES.
  - HOLD: entered on res=1. When res=0, go to STRETCH with counter=0.
  - STRETCH: counter increments each cycle. When counter==RST_CYCLES-1, go to RUN on the next edge.
  - RUN: nres=1, run=1. If sw_res=1, go to SWRES with counter=0.
  - SWRES: counter increments while below SW_RST_CYCLES-1 and saturates there. Return to RUN only when counter==SW_RST_CYCLES-1 and sw_res=0.
  - res=1 in any state forces HOLD on the next edge, including mid-STRETCH and mid-SWRES.
- nres and run are registered outputs. After res falls, nres rises exactly RST_CYCLES+1 edges later (HOLD->STRETCH takes 1 edge, then RST_CYCLES edges in STRETCH).
- Pad drivers:
  - pad_oe <= pin_dir & {run}; pad_o <= pin_out & {run}. One-cycle latency.
  - Pads are forced tristate and low in every state other than RUN. This includes SWRES, so pins never float to stale core values while the core is reset.
- Input path:
  - pad_in passes through SYNC_STAGES flops; the last stage is pin_in. Latency is SYNC_STAGES cycles.
  - Synchronisers keep running in every state except res=1.
- Change strobe:
  - pin_chg[p] is registered and equals 1 when the bank-p slice of pin_in differs from its value on the previous cycle.
  - It is held 0 while run=0, so no spurious strobe fires when leaving reset.
- Width rules: all buses are flat PORTS*WIDTH vectors, bank 0 in the LSBs. The counter compares unsigned. RST_CYCLES must fit in CNT_W bits; elaboration fails otherwise.
- Simultaneous events: res dominates sw_res. sw_res asserted during STRETCH is ignored until RUN is reached.

Decomposition:
- Shared package/include (features.v style) holds:
  - sequencer state encodings SEQ_HOLD=2'd0, SEQ_STRETCH=2'd1, SEQ_RUN=2'd2, SEQ_SWRES=2'd3;
  - the default parameter values.
- One sub-module, pin_sync: a WIDTH-wide, SYNC_STAGES-deep synchroniser plus change detector, instantiated PORTS times by a generate loop.
- The sequencer and pad registers stay in pin_bank_ctrl.

Test Plan:
- Reset release (res=1 for 5 cycles, then 0; RST_CYCLES=16):
  - nres=0 and pad_oe=0 throughout;
  - nres rises on edge 17 after res falls, with run rising on the same edge.
- Output path (in RUN, bank1 pin_dir=32'hFFFF0000, pin_out=32'hA5A5A5A5):
  - one cycle later pad_oe[63:32]=32'hFFFF0000 and pad_o[63:32]=32'hA5A5A5A5;
  - bank0 is unchanged.
- Synchroniser (pad_in[5] toggles 0->1; SYNC_STAGES=2):
  - pin_in[5] rises 2 cycles later;
  - pin_chg[0] pulses for exactly 1 cycle on the following edge;
  - pin_chg[1] stays 0.
- Software reset (sw_res held 1 for 10 cycles in RUN; SW_RST_CYCLES=4):
  - nres low and pad_oe=0 for the whole hold;
  - nres returns high 1 edge after sw_res drops.
- Short software reset (sw_res=1 for 1 cycle):
  - nres stays low for exactly SW_RST_CYCLES=4 cycles, then RUN.
- Reset mid-operation (res=1 asserted at STRETCH counter=7, and again in SWRES):
  - next edge enters HOLD with counter=0 and all outputs at reset values;
  - after res falls, the full RST_CYCLES stretch repeats.
